bringup_pattern: RTL and testbench

Multi-channel bring-up pattern generator: drives `CHANNELS` output pins with a selectable test pattern advanced at a fixed, parameterised rate. It generalises the single-pin square-wave bring-up driver to a bus, with runtime mode selection and a tick strobe for scope triggering. It sits directly behind board-level test pins during board bring-up and connects to nothing else in the datapath.

---
 rtl/bringup_pkg.sv | 32 +++
 rtl/bringup_tick.sv | 41 ++++
 rtl/bringup_pattern.sv | 106 ++++++++++
 tb/tb_bringup_pattern.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/bringup_pkg.sv
// Shared constants for the bring-up pattern generator.
// Optional feature: BRINGUP_PATTERN_PRBS_EN enables mode 4 (PRBS7).
package bringup_pkg;

    localparam logic [2:0] MODE_IDLE   = 3'd0;
    localparam logic [2:0] MODE_SQUARE = 3'd1;
    localparam logic [2:0] MODE_WALK   = 3'd2;
    localparam logic [2:0] MODE_COUNT  = 3'd3;
    localparam logic [2:0] MODE_PRBS   = 3'd4;

    // PRBS7, x^7 + x^6 + 1: feedback taps are LFSR bits 6 and 5.
    localparam logic [6:0] PRBS_SEED   = 7'h01;
    localparam int         PRBS_TAP_HI = 6;
    localparam int         PRBS_TAP_LO = 5;

    // Folds unsupported/undefined mode codes onto IDLE.
    function automatic logic [2:0] decode_mode(input logic [2:0] m);
        logic [2:0] r;
        r = MODE_IDLE;
        case (m)
            MODE_SQUARE: r = MODE_SQUARE;
            MODE_WALK:   r = MODE_WALK;
            MODE_COUNT:  r = MODE_COUNT;
`ifdef BRINGUP_PATTERN_PRBS_EN
            MODE_PRBS:   r = MODE_PRBS;
`endif
            default:     r = MODE_IDLE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/bringup_tick.sv
// Prescaler: down-counter from HALF-1 that strobes tick_o at zero.
// restart_i reloads the counter and suppresses that cycle's strobe.
module bringup_tick #(
    parameter int HALF = 4
) (
    input  logic clock,
    input  logic reset_n,
    input  logic restart_i,
    output logic tick_o
);

    localparam int COUNTER_BITS = (HALF > 1) ? $clog2(HALF) : 1;
    localparam logic [COUNTER_BITS-1:0] RELOAD = COUNTER_BITS'(HALF - 1);

    logic [COUNTER_BITS-1:0] count_q;
    logic [COUNTER_BITS-1:0] count_d;

    // Strobe at zero unless a restart overrides it.
    always_comb begin
        tick_o = (count_q == '0) && !restart_i;
    end

    // Reload on restart or on reaching zero, otherwise count down.
    always_comb begin
        if (restart_i || (count_q == '0)) begin
            count_d = RELOAD;
        end else begin
            count_d = count_q - 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= RELOAD;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/bringup_pattern.sv
// Multi-channel bring-up pattern generator (IDLE/SQUARE/WALK/COUNT,
// plus PRBS7 on mode 4 when BRINGUP_PATTERN_PRBS_EN is defined).
// A mode change restarts the prescaler and loads the entry pattern.
module bringup_pattern
    import bringup_pkg::*;
#(
    parameter int CLOCKS_PER_CYCLE = 120,
    parameter int CHANNELS         = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [2:0]          mode_i,
    output logic [CHANNELS-1:0] pins_o,
    output logic                tick_o
);

    localparam int HALF = CLOCKS_PER_CYCLE / 2;

    logic [2:0]          mode_q, mode_d;
    logic                phase_q, phase_d;
    logic [CHANNELS-1:0] pins_q, pins_d;
    logic                tick_q, tick_d;
    logic                mode_change;
    logic                tick;
    logic [2:0]          eff_new;
    logic [2:0]          eff_cur;
`ifdef BRINGUP_PATTERN_PRBS_EN
    logic [6:0]          lfsr_q, lfsr_d;
    logic                prbs_bit;
    logic [CHANNELS:0]   prbs_shift;
`endif

    bringup_tick #(
        .HALF (HALF)
    ) u_tick (
        .clock     (clock),
        .reset_n   (reset_n),
        .restart_i (mode_change),
        .tick_o    (tick)
    );

    // Next-state for mode, pattern and strobe; a mode change beats a tick.
    always_comb begin
        mode_change = (mode_i != mode_q);
        eff_new     = decode_mode(mode_i);
        eff_cur     = decode_mode(mode_q);
        mode_d      = mode_i;
        phase_d     = phase_q;
        pins_d      = pins_q;
        tick_d      = tick;
`ifdef BRINGUP_PATTERN_PRBS_EN
        lfsr_d      = lfsr_q;
        prbs_bit    = lfsr_q[PRBS_TAP_HI] ^ lfsr_q[PRBS_TAP_LO];
        prbs_shift  = {pins_q, prbs_bit};
`endif
        if (mode_change) begin
            phase_d = 1'b0;
`ifdef BRINGUP_PATTERN_PRBS_EN
            lfsr_d  = PRBS_SEED;
`endif
            pins_d  = (eff_new == MODE_WALK) ? CHANNELS'(1) : '0;
        end else if (tick) begin
            case (eff_cur)
                MODE_SQUARE: begin
                    phase_d = ~phase_q;
                    pins_d  = {CHANNELS{~phase_q}};
                end
                // Rotate left; with one channel the pin simply stays high.
                MODE_WALK:   pins_d = (pins_q << 1) | (pins_q >> (CHANNELS - 1));
                MODE_COUNT:  pins_d = pins_q + 1'b1;
`ifdef BRINGUP_PATTERN_PRBS_EN
                MODE_PRBS: begin
                    lfsr_d = {lfsr_q[5:0], prbs_bit};
                    pins_d = prbs_shift[CHANNELS-1:0];
                end
`endif
                default:     pins_d = '0;
            endcase
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            mode_q  <= MODE_IDLE;
            phase_q <= 1'b0;
            pins_q  <= '0;
            tick_q  <= 1'b0;
`ifdef BRINGUP_PATTERN_PRBS_EN
            lfsr_q  <= PRBS_SEED;
`endif
        end else begin
            mode_q  <= mode_d;
            phase_q <= phase_d;
            pins_q  <= pins_d;
            tick_q  <= tick_d;
`ifdef BRINGUP_PATTERN_PRBS_EN
            lfsr_q  <= lfsr_d;
`endif
        end
    end

    assign pins_o = pins_q;
    assign tick_o = tick_q;

endmodule

// File: tb/tb_bringup_pattern.sv
// Self-checking bench for bringup_pattern (CLOCKS_PER_CYCLE=8, CHANNELS=4).
// Reference model tracks ticks since the last mode entry and derives the
// expected pins arithmetically; works with or without BRINGUP_PATTERN_PRBS_EN.
module tb_bringup_pattern;

    localparam int CPC  = 8;
    localparam int CH   = 4;
    localparam int HALF = CPC / 2;
    localparam int NBITS = 4200;

    logic          clock = 1'b0;
    logic          reset_n;
    logic [2:0]    mode_i;
    logic [CH-1:0] pins_o;
    logic          tick_o;

    int tests_run    = 0;
    int tests_failed = 0;

    // Model state: active mode, clocks since reload, ticks since entry.
    int mode_m;
    int since_m;
    int k_m;
    bit tick_m;
    bit prbs_h [NBITS];

    bringup_pattern #(
        .CLOCKS_PER_CYCLE (CPC),
        .CHANNELS         (CH)
    ) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .mode_i  (mode_i),
        .pins_o  (pins_o),
        .tick_o  (tick_o)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int eff_mode(input int m);
        if (m >= 1 && m <= 3) return m;
`ifdef BRINGUP_PATTERN_PRBS_EN
        if (m == 4) return 4;
`endif
        return 0;
    endfunction

    // PRBS output bit produced by the j-th tick (j >= 1).
    function automatic bit prbs_out(input int j);
        if (j < 1 || j + 6 >= NBITS) return 1'b0;
        return prbs_h[j + 6];
    endfunction

    function automatic logic [31:0] exp_pins();
        logic [31:0] r;
        r = 0;
        case (eff_mode(mode_m))
            1: r = (k_m % 2 == 1) ? ((1 << CH) - 1) : 0;
            2: r = 1 << (k_m % CH);
            3: r = k_m % (1 << CH);
            4: for (int b = 0; b < CH; b++) r[b] = prbs_out(k_m - b);
            default: r = 0;
        endcase
        return r;
    endfunction

    task automatic model_reset();
        mode_m = 0; since_m = 0; k_m = 0; tick_m = 0;
    endtask

    task automatic model_step();
        if (int'(mode_i) != mode_m) begin
            mode_m = int'(mode_i); since_m = 0; k_m = 0; tick_m = 0;
        end else begin
            since_m++;
            if (since_m == HALF) begin
                since_m = 0; tick_m = 1; k_m++;
            end else begin
                tick_m = 0;
            end
        end
    endtask

    task automatic step_check(input string tag);
        @(posedge clock);
        model_step();
        @(negedge clock);
        check({tag, "_pins"}, 32'(pins_o), exp_pins());
        check({tag, "_tick"}, 32'(tick_o), 32'(tick_m));
    endtask

    task automatic run_mode(input int m, input int cycles, input string tag);
        mode_i = 3'(m);
        $display("[TB] segment %s mode=%0d cycles=%0d", tag, m, cycles);
        for (int i = 0; i < cycles; i++) step_check(tag);
    endtask

    // Asynchronous reset asserted between edges, checked immediately.
    task automatic mid_reset();
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_pins", 32'(pins_o), 0);
        check("rst_async_tick", 32'(tick_o), 0);
        @(posedge clock);
        @(negedge clock);
        check("rst_hold_pins", 32'(pins_o), 0);
        reset_n = 1'b1;
        model_reset();
        $display("[TB] reset pulse at %0t", $time);
    endtask

    initial begin
        // Reference PRBS7 stream: h[n+1] = h[n-6] ^ h[n-5], seed 7'h01.
        for (int n = 0; n < NBITS; n++) prbs_h[n] = 1'b0;
        prbs_h[6] = 1'b1;
        for (int n = 6; n < NBITS - 1; n++) prbs_h[n + 1] = prbs_h[n - 6] ^ prbs_h[n - 5];

        reset_n = 1'b0;
        mode_i  = 3'd1;
        model_reset();
        repeat (3) begin
            @(negedge clock);
            check("reset_pins", 32'(pins_o), 0);
            check("reset_tick", 32'(tick_o), 0);
        end
        reset_n = 1'b1;

        run_mode(1, 40, "square");
        run_mode(2, 5 * HALF + 4, "walk");
        run_mode(3, 17 * HALF + 2, "count");

        // Switch 3->1 exactly on the cycle the prescaler sits at zero.
        for (int i = 0; i < HALF && since_m != HALF - 1; i++) step_check("align");
        check("align_reached", 32'(since_m), HALF - 1);
        mode_i = 3'd1;
        step_check("switch");
        check("switch_no_tick", 32'(tick_o), 0);
        run_mode(1, 2 * HALF + 1, "after_switch");

        run_mode(6, 3 * HALF + 1, "mode6");
        run_mode(4, 135 * HALF + 3, "mode4");
        mid_reset();
        run_mode(4, 6 * HALF, "mode4_after_rst");

        // Randomized segments with occasional resets.
        for (int s = 0; s < 30; s++) begin
            if ($urandom_range(9, 0) == 0) mid_reset();
            run_mode(int'($urandom_range(7, 0)), int'($urandom_range(30, 1)), "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
